// File: rtl/hamming_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hamming_serial_rx                                            |
// | Description : Serial SECDED Hamming receiver with valid/ready result port  |
// |               and saturating single/double error counters.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package hamming_serial_rx_pkg;

    // Smallest m with 2**m >= m + k + 1.
    function automatic int calculate_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < (m + k + 1)) m++;
        return m;
    endfunction

    // Codeword position of data bit d (positions that are not powers of two).
    function automatic int data_pos(input int d);
        int pos;
        int seen;
        pos  = 0;
        seen = -1;
        while (seen < d) begin
            pos++;
            if ((pos & (pos - 1)) != 0) seen++;
        end
        return pos;
    endfunction

endpackage

module hamming_serial_rx
    import hamming_serial_rx_pkg::*;
#(
    parameter  int K     = 8,
    parameter  int CNT_W = 16,
    localparam int M     = calculate_m(K),
    localparam int N     = M + K
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ser_d_i,
    input  logic             ser_valid_i,
    input  logic             ser_sof_i,
    output logic             ser_ready_o,
    output logic [K-1:0]     q_o,
    output logic [M-1:0]     syndrome_o,
    output logic             sb_err_o,
    output logic             db_err_o,
    output logic             sb_fix_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             abort_o,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o
);

    localparam int             C_CW       = $clog2(N + 1);
    localparam logic [C_CW-1:0] C_LAST    = C_CW'(N);
    localparam logic [M-1:0]    C_N_SYN   = M'(N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N:0]       r_cw;
    logic [C_CW-1:0]  r_cnt;
    logic             r_abort;
    logic [K-1:0]     r_q;
    logic [M-1:0]     r_syn;
    logic             r_sb;
    logic             r_db;
    logic             r_fix;
    logic             r_valid;
    logic [CNT_W-1:0] r_sb_cnt;
    logic [CNT_W-1:0] r_db_cnt;

    logic             w_accept;
    logic [M-1:0]     w_syn;
    logic             w_par;
    logic             w_syn_nz;
    logic             w_syn_in;
    logic             w_sb;
    logic             w_db;
    logic             w_do_flip;
    logic [K-1:0]     w_data;

    assign ser_ready_o = (r_state == S_IDLE) || (r_state == S_SHIFT);
    assign w_accept    = ser_valid_i && ser_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && ser_sof_i) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_accept && !ser_sof_i && (r_cnt == C_LAST)) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_valid && ready_i) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A SOF always restarts the frame, even in the middle of one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cw    <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= (r_state == S_SHIFT) && w_accept && ser_sof_i;
            if (w_accept) begin
                if (ser_sof_i) begin
                    r_cw[0] <= ser_d_i;
                    r_cnt   <= C_CW'(1);
                end else if (r_state == S_SHIFT) begin
                    r_cw[r_cnt] <= ser_d_i;
                    r_cnt       <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_syn = '0;
        for (int i = 1; i <= N; i++) begin
            if (r_cw[i]) w_syn = w_syn ^ M'(i);
        end
    end

    assign w_par     = ^r_cw;
    assign w_syn_nz  = |w_syn;
    assign w_syn_in  = (w_syn <= C_N_SYN);
    assign w_sb      = w_par && (!w_syn_nz || w_syn_in);
    assign w_db      = (!w_par && w_syn_nz) || (w_par && !w_syn_in);
    assign w_do_flip = w_par && w_syn_nz && w_syn_in;

    // Only data positions need the correction; parity-bit flips leave data untouched.
    generate
        for (genvar gd = 0; gd < K; gd++) begin : g_data
            localparam int           C_POS     = data_pos(gd);
            localparam logic [M-1:0] C_POS_SYN = M'(C_POS);
            assign w_data[gd] = r_cw[C_POS] ^ (w_do_flip && (w_syn == C_POS_SYN));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q      <= '0;
            r_syn    <= '0;
            r_sb     <= 1'b0;
            r_db     <= 1'b0;
            r_fix    <= 1'b0;
            r_valid  <= 1'b0;
            r_sb_cnt <= '0;
            r_db_cnt <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_q     <= w_data;
                r_syn   <= w_syn;
                r_sb    <= w_sb;
                r_db    <= w_db;
                r_fix   <= w_sb;
                r_valid <= 1'b1;
                if (w_sb && (r_sb_cnt != '1)) r_sb_cnt <= r_sb_cnt + 1'b1;
                if (w_db && (r_db_cnt != '1)) r_db_cnt <= r_db_cnt + 1'b1;
            end else if ((r_state == S_HOLD) && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign q_o        = r_q;
    assign syndrome_o = r_syn;
    assign sb_err_o   = r_sb;
    assign db_err_o   = r_db;
    assign sb_fix_o   = r_fix;
    assign valid_o    = r_valid;
    assign abort_o    = r_abort;
    assign sb_cnt_o   = r_sb_cnt;
    assign db_cnt_o   = r_db_cnt;

endmodule

`default_nettype wire

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Serial-link receiver for the SECDED Hamming code produced by the team's encoder. Deserialises one codeword per frame from a 1-bit stream, performs single-error correction / double-error detection, and presents the data word plus status flags on a valid/ready output port. Saturating single- and double-error counters support link health monitoring. It sits at the receive end of a serial channel whose transmit end runs the encoder.

## Interface
- K, 8, information bits per codeword.
- m, calculate_m(K) (smallest m with 2**m >= m+K+1; 4 for K=8), Hamming parity bits.
- n, m+K, Hamming length; serial frame is n+1 bits including overall parity.
- CNT_W, 16, width of each error counter.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- ser_d_i  in  1  serial codeword bit.
- ser_valid_i  in  1  ser_d_i valid this cycle.
- ser_sof_i  in  1  start of frame; qualified by ser_valid_i, marks codeword bit 0.
- ser_ready_o  out  1  receiver accepts a bit this cycle.
- q_o  out  K  decoded (corrected where possible) data.
- syndrome_o  out  m  Hamming syndrome of the received frame.
- sb_err_o  out  1  single-bit error detected.
- db_err_o  out  1  uncorrectable (double-bit) error detected.
- sb_fix_o  out  1  single-bit error corrected.
- valid_o  out  1  decoded result valid.
- ready_i  in  1  consumer accepts result.
- abort_o  out  1  one-cycle pulse: partial frame discarded by a new SOF.
- sb_cnt_o  out  CNT_W  frames with sb_err_o, saturating.
- db_cnt_o  out  CNT_W  frames with db_err_o, saturating.

## Operation
- Codeword c[n:0]: c[0] = overall even parity over c[n:1]; c[2**i] = Hamming parity i; data bits occupy the remaining positions 3,5,6,7,9,... ascending, d[0] at lowest. Serial order: c[0] first, c[n] last.
- A bit is accepted when ser_valid_i && ser_ready_o.
- FSM: IDLE, SHIFT, DECODE, HOLD.
  - IDLE: accepted bit with ser_sof_i stored as c[0], bit count = 1, go SHIFT; accepted bits without SOF discarded.
  - SHIFT: each accepted bit stored at c[count]; accepting c[n] goes DECODE. Accepted bit with ser_sof_i restarts the frame (bit becomes c[0], count=1) and pulses abort_o next cycle. Idle gaps (ser_valid_i low) allowed anywhere.
  - DECODE: one cycle; computes s = XOR of indices i (1..n) with c[i]=1, and p = XOR of c[n:0]; registers all result outputs; valid_o=1; go HOLD.
  - HOLD: outputs stable; on valid_o && ready_i go IDLE, valid_o=0.
- ser_ready_o = 1 in IDLE and SHIFT, 0 in DECODE and HOLD.
- Decode: s=0,p=0: clean. s!=0,p=1,s<=n: flip c[s], sb_err=sb_fix=1. s=0,p=1: parity-bit error, sb_err=sb_fix=1, data unchanged. s!=0,p=0: db_err=1, data raw. s>n,p=1: db_err=1, data raw. syndrome_o = s always.
- Counters increment in DECODE when sb_err / db_err set; hold at 2**CNT_W-1; cleared only by reset.
- Result outputs hold last values after handshake until the next DECODE.

## Timing
- Reset: state IDLE; q_o, syndrome_o, all flags, valid_o, abort_o, counters = 0; ser_ready_o = 1.
- Last bit accepted at edge E: DECODE during cycle after E; valid_o and results visible after edge E+1.
- Handshake at edge H: valid_o low and ser_ready_o high after H; first bit of next frame accepted at H+1 earliest.
- Minimum frame period: n+1 bit cycles + DECODE + 1 handshake cycle (n+3 cycles for gapless stream and ready_i high).
- abort_o high exactly one cycle, after the restarting edge.
- Reset asserted mid-frame or in HOLD: immediate return to reset values; partial frame lost, no abort_o.

## Test plan
- Clean frame c=13'h14EB (K=8), gapless, ready_i=1 -> q_o=8'hAF, syndrome_o=0, all flags 0, valid_o two cycles after last bit.
- c=13'h14AB (c[6] flipped) -> q_o=8'hAF, syndrome_o=4'b0110, sb_err_o=sb_fix_o=1, sb_cnt_o=1.
- c=13'h14EA (c[0] flipped) -> q_o=8'hAF, syndrome_o=0, sb_err_o=sb_fix_o=1, db_err_o=0.
- c[3] and c[5] flipped -> syndrome_o=4'b0110, db_err_o=1, sb_fix_o=0, q_o=8'hAC, db_cnt_o=1; with CNT_W=2, five such frames -> db_cnt_o=3.
- Clean frame, ready_i low 5 cycles while second frame driven -> ser_ready_o=0, outputs stable; bits during HOLD not captured; after handshake second frame decodes correctly.
- SOF after 5 bits then full clean frame -> abort_o one pulse, q_o=8'hAF; rst_ni low mid-frame -> all outputs zero, ser_ready_o=1, next frame decodes correctly.
